// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Outputs are decoded from the current state. A memory wait holds until mem_ready is seen with mem_req=1.
module multicycle_ctrl #(
  parameter int RESET_STATE_FETCH = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             zero_flag,
  output logic             pc_we,
  output logic             ir_we,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             b_arith,
  output logic [3:0]       alu_control,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_LUI      = 4'd4;
  localparam logic [3:0] S_AUIPC    = 4'd5;
  localparam logic [3:0] S_ALU_WB   = 4'd6;
  localparam logic [3:0] S_MEM_ADDR = 4'd7;
  localparam logic [3:0] S_MEM_RD   = 4'd8;
  localparam logic [3:0] S_LD_WB    = 4'd9;
  localparam logic [3:0] S_MEM_WR   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JALR     = 4'd13;
  localparam logic [3:0] S_ILLEGAL  = 4'd14;

  // FETCH is the only supported reset state, whatever the parameter says.
  localparam logic [3:0] RST_STATE = (RESET_STATE_FETCH != 0) ? S_FETCH : S_FETCH;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b0110;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_b5;
  logic [3:0] alu_f3;
  logic [3:0] br_op;
  logic       br_bad;
  logic       unused_instr;

  logic       retire;
  logic       pc_we_c, ir_we_c, iord_c, mem_req_c, mem_we_c, b_arith_c, reg_we_c, illegal_c;
  logic [1:0] pc_src_c, alu_src_a_c, alu_src_b_c, wb_sel_c;
  logic [3:0] alu_control_c;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign f7_b5        = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    alu_f3 = ALU_ADD;
    case (funct3)
      3'b000: alu_f3 = ALU_ADD;
      3'b001: alu_f3 = 4'b0111;
      3'b010: alu_f3 = 4'b0001;
      3'b011: alu_f3 = 4'b0010;
      3'b100: alu_f3 = 4'b0101;
      3'b101: alu_f3 = 4'b1000;
      3'b110: alu_f3 = 4'b0100;
      default: alu_f3 = 4'b0011;
    endcase
  end

  always_comb begin
    br_op  = ALU_ADD;
    br_bad = 1'b0;
    case (funct3)
      3'b000: br_op = 4'b1010;
      3'b001: br_op = 4'b1011;
      3'b100: br_op = 4'b1100;
      3'b101: br_op = 4'b1110;
      3'b110: br_op = 4'b1101;
      3'b111: br_op = 4'b1111;
      default: br_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    pc_we_c       = 1'b0;
    ir_we_c       = 1'b0;
    pc_src_c      = 2'b00;
    iord_c        = 1'b0;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    alu_src_a_c   = 2'b00;
    alu_src_b_c   = 2'b00;
    b_arith_c     = 1'b0;
    alu_control_c = ALU_ADD;
    reg_we_c      = 1'b0;
    wb_sel_c      = 2'b00;
    illegal_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = 2'b01;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the PC-relative target into ALUOut while decoding.
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        case (opcode)
          7'b0110011:             state_d = S_EXEC_R;
          7'b0010011:             state_d = S_EXEC_I;
          7'b0000011, 7'b0100011: state_d = S_MEM_ADDR;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = (funct3 == 3'b000) ? S_JALR : S_ILLEGAL;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_AUIPC;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = (funct3 == 3'b000 && f7_b5) ? ALU_SUB : alu_f3;
        b_arith_c     = (funct3 == 3'b101) && f7_b5;
        state_d       = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_c   = 2'b10;
        alu_src_b_c   = 2'b10;
        alu_control_c = alu_f3;
        b_arith_c     = (funct3 == 3'b101) && f7_b5;
        state_d       = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_b_c   = 2'b10;
        alu_control_c = ALU_LUI;
        state_d       = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we_c = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b10;
        state_d     = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        reg_we_c = 1'b1;
        wb_sel_c = 2'b01;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a_c = 2'b10;
        if (br_bad) begin
          state_d = S_ILLEGAL;
        end else begin
          alu_control_c = br_op;
          pc_we_c       = zero_flag;
          pc_src_c      = 2'b01;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_JAL: begin
        reg_we_c = 1'b1;
        wb_sel_c = 2'b10;
        pc_we_c  = 1'b1;
        pc_src_c = 2'b01;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JALR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b10;
        pc_we_c     = 1'b1;
        pc_src_c    = 2'b10;
        reg_we_c    = 1'b1;
        wb_sel_c    = 2'b10;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      default: illegal_c = 1'b1;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Gating with rst_n drops the FETCH request the instant reset asserts.
  assign {pc_we, ir_we, pc_src, iord, mem_req, mem_we, alu_src_a, alu_src_b,
          b_arith, alu_control, reg_we, wb_sel, illegal} =
         rst_n ? {pc_we_c, ir_we_c, pc_src_c, iord_c, mem_req_c, mem_we_c, alu_src_a_c,
                  alu_src_b_c, b_arith_c, alu_control_c, reg_we_c, wb_sel_c, illegal_c} : 20'd0;

  assign retired = retired_q;

endmodule
